// File: rtl/sd_cmd_master.sv
// Purpose : SD command sequencer. Latches a host command request, drives the
//           command serialiser through REQ/ACK and reports done/response/errors.
// Latency : NEW_CMD to SER_REQ is 1 cycle. A final status edge (after sync) reaches
//           CMD_DONE in at least 2 cycles. A timeout aborts in the cycle after the limit.
// Backpressure: NEW_CMD is ignored while BUSY. Status events are held off by SER_ACK.
//
// Ports:
//   SD_CLK_IN, RST_IN            clock and asynchronous active-high reset
//   NEW_CMD, CMD_INDEX, CMD_ARG,
//   CMD_SETTING, TIMEOUT_IN      host-side command request
//   BUSY, CMD_DONE, RESPONSE,
//   RSP_INDEX, ERR_FLAGS         host-side status; ERR_FLAGS = {idx, crc, timeout}
//   SER_SETTING, SER_CMD,
//   SER_REQ, SER_ACK,
//   SER_GO_IDLE                  towards the serialiser
//   SER_READY, SER_STATUS_REQ,
//   SER_STATUS, SER_RSP          from the serialiser (READY and STATUS_REQ are synchronised)
module sd_cmd_master #(
    parameter int TOUT_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SD_CLK_IN,
    input  logic              RST_IN,
    input  logic              NEW_CMD,
    input  logic [5:0]        CMD_INDEX,
    input  logic [31:0]       CMD_ARG,
    input  logic [15:0]       CMD_SETTING,
    input  logic [TOUT_W-1:0] TIMEOUT_IN,
    output logic              BUSY,
    output logic              CMD_DONE,
    output logic [31:0]       RESPONSE,
    output logic [5:0]        RSP_INDEX,
    output logic [2:0]        ERR_FLAGS,
    output logic [15:0]       SER_SETTING,
    output logic [39:0]       SER_CMD,
    output logic              SER_REQ,
    output logic              SER_ACK,
    output logic              SER_GO_IDLE,
    input  logic              SER_READY,
    input  logic              SER_STATUS_REQ,
    input  logic [15:0]       SER_STATUS,
    input  logic [39:0]       SER_RSP
);

    // Serialiser phase code that carries a response word.
    localparam logic [3:0] PHASE_RSP = 4'b0110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        ACTIVE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] ready_sync;
    logic [SYNC_STAGES-1:0] sreq_sync;
    logic                   ready_s;
    logic                   sreq_s;
    logic                   sreq_q;
    logic                   sreq_rise;

    logic [TOUT_W-1:0]      tout_cnt;
    logic [TOUT_W-1:0]      tout_lim;
    logic                   idx_chk;

    logic                   tout_hit;
    logic                   final_evt;
    logic                   accept_cmd;
    logic                   req_nxt;
    logic                   ack_nxt;
    logic                   done_nxt;

    // Status bits and response framing bits the sequencer has no use for.
    logic                   unused_bits;
    assign unused_bits = &{1'b0, SER_STATUS[15:7], SER_STATUS[4], SER_RSP[39:38]};

    // ------------------------------------------------------------------
    // Handshake synchronisers. The READY chain resets to all ones so the
    // serialiser is treated as idle straight out of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            ready_sync <= '1;
            sreq_sync  <= '0;
            sreq_q     <= 1'b0;
        end else begin
            ready_sync[0] <= SER_READY;
            sreq_sync[0]  <= SER_STATUS_REQ;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ready_sync[i] <= ready_sync[i-1];
                sreq_sync[i]  <= sreq_sync[i-1];
            end
            sreq_q <= sreq_sync[SYNC_STAGES-1];
        end
    end

    assign ready_s   = ready_sync[SYNC_STAGES-1];
    assign sreq_s    = sreq_sync[SYNC_STAGES-1];
    assign sreq_rise = sreq_s & ~sreq_q;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    assign accept_cmd = (state == IDLE) && NEW_CMD;
    assign tout_hit   = (state != IDLE) && (tout_lim != '0) && (tout_cnt == tout_lim);
    assign final_evt  = (state == ACTIVE) && sreq_rise && SER_STATUS[6];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next-cycle output values. Timeout is checked
    // first in every busy state so it wins over a coincident final event.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        req_nxt   = 1'b0;
        ack_nxt   = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (NEW_CMD) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (tout_hit) begin
                    state_nxt = IDLE;
                end else if (!ready_s) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (tout_hit) begin
                    state_nxt = IDLE;
                end else if (final_evt) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                if (tout_hit || ready_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        req_nxt  = (state_nxt == ISSUE);
        // In ACTIVE the acknowledge follows the synced request; once the final
        // event is taken it is held until the serialiser reports idle.
        ack_nxt  = ((state_nxt == ACTIVE) && sreq_s) || (state_nxt == FINISH);
        done_nxt = (state != IDLE) && (state_nxt == IDLE);
    end

    // ------------------------------------------------------------------
    // Registered handshake / status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            BUSY        <= 1'b0;
            CMD_DONE    <= 1'b0;
            SER_REQ     <= 1'b0;
            SER_ACK     <= 1'b0;
            SER_GO_IDLE <= 1'b0;
        end else begin
            BUSY        <= (state_nxt != IDLE);
            CMD_DONE    <= done_nxt;
            SER_REQ     <= req_nxt;
            SER_ACK     <= ack_nxt;
            SER_GO_IDLE <= tout_hit;
        end
    end

    // ------------------------------------------------------------------
    // Command latch, timeout counter, response capture and error flags
    // ------------------------------------------------------------------
    always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            SER_CMD     <= '0;
            SER_SETTING <= '0;
            idx_chk     <= 1'b0;
            tout_lim    <= '0;
            tout_cnt    <= '0;
            ERR_FLAGS   <= '0;
            RESPONSE    <= '0;
            RSP_INDEX   <= '0;
        end else begin
            if (accept_cmd) begin
                SER_CMD     <= {2'b01, CMD_INDEX, CMD_ARG};
                // Bit 15 is the local index-check enable; the serialiser never sees it.
                SER_SETTING <= {1'b0, CMD_SETTING[14:0]};
                idx_chk     <= CMD_SETTING[15];
                tout_lim    <= TIMEOUT_IN;
                tout_cnt    <= '0;
                ERR_FLAGS   <= '0;
            end else begin
                // Saturate so a long-running command with timeout disabled never wraps.
                if ((state != IDLE) && (tout_cnt != '1)) begin
                    tout_cnt <= tout_cnt + 1'b1;
                end

                if (tout_hit) begin
                    ERR_FLAGS[0] <= 1'b1;
                end else if (final_evt) begin
                    if (SER_STATUS[3:0] == PHASE_RSP) begin
                        RESPONSE  <= SER_RSP[31:0];
                        RSP_INDEX <= SER_RSP[37:32];
                    end
                    ERR_FLAGS[1] <= SER_SETTING[7] & ~SER_STATUS[5];
                    ERR_FLAGS[2] <= idx_chk & (SER_RSP[37:32] != SER_CMD[37:32]);
                end
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_master.sv
// Purpose : randomized bench for sd_cmd_master with a serialiser model and a
//           scoreboard; expected results come from a command-level model.
// Latency : n/a (testbench).
// Backpressure: the serialiser model honours the REQ/ACK and READY handshakes.
module tb_sd_cmd_master;

    localparam int TOUT_W = 16;

    logic              SD_CLK_IN = 1'b0;
    logic              RST_IN;
    logic              NEW_CMD;
    logic [5:0]        CMD_INDEX;
    logic [31:0]       CMD_ARG;
    logic [15:0]       CMD_SETTING;
    logic [TOUT_W-1:0] TIMEOUT_IN;
    logic              BUSY;
    logic              CMD_DONE;
    logic [31:0]       RESPONSE;
    logic [5:0]        RSP_INDEX;
    logic [2:0]        ERR_FLAGS;
    logic [15:0]       SER_SETTING;
    logic [39:0]       SER_CMD;
    logic              SER_REQ;
    logic              SER_ACK;
    logic              SER_GO_IDLE;
    logic              SER_READY;
    logic              SER_STATUS_REQ;
    logic [15:0]       SER_STATUS;
    logic [39:0]       SER_RSP;

    sd_cmd_master #(.TOUT_W(TOUT_W), .SYNC_STAGES(2)) dut (
        .SD_CLK_IN      (SD_CLK_IN),
        .RST_IN         (RST_IN),
        .NEW_CMD        (NEW_CMD),
        .CMD_INDEX      (CMD_INDEX),
        .CMD_ARG        (CMD_ARG),
        .CMD_SETTING    (CMD_SETTING),
        .TIMEOUT_IN     (TIMEOUT_IN),
        .BUSY           (BUSY),
        .CMD_DONE       (CMD_DONE),
        .RESPONSE       (RESPONSE),
        .RSP_INDEX      (RSP_INDEX),
        .ERR_FLAGS      (ERR_FLAGS),
        .SER_SETTING    (SER_SETTING),
        .SER_CMD        (SER_CMD),
        .SER_REQ        (SER_REQ),
        .SER_ACK        (SER_ACK),
        .SER_GO_IDLE    (SER_GO_IDLE),
        .SER_READY      (SER_READY),
        .SER_STATUS_REQ (SER_STATUS_REQ),
        .SER_STATUS     (SER_STATUS),
        .SER_RSP        (SER_RSP)
    );

    always #5 SD_CLK_IN = ~SD_CLK_IN;

    int cyc = 0;
    always @(posedge SD_CLK_IN) cyc <= cyc + 1;

    // Command kinds driven by the serialiser model
    localparam int K_NORSP = 0;   // final event in phase 0100, no ACK wait
    localparam int K_RSP   = 1;   // final event in phase 0110 with response word
    localparam int K_TOUT  = 2;   // serialiser accepts and then goes silent

    typedef struct {
        logic [39:0] cmd;
        logic [15:0] setting;
        logic [31:0] resp;
        logic [5:0]  ridx;
        logic [2:0]  err;
        int          done_cyc;    // -1 when completion time is model dependent
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          go_cnt = 0;
    int          n_tout_exp = 0;
    logic [31:0] m_resp = '0;
    logic [5:0]  m_ridx = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return SER_REQ;
            1:       return SER_ACK;
            2:       return BUSY;
            default: return SER_GO_IDLE;
        endcase
    endfunction

    // Bounded wait for one DUT output to reach a level; an expired budget fails.
    task automatic wait_sig(input int which, input logic lvl, input int lim, input string nm);
        for (int k = 0; k < lim && sig(which) !== lvl; k++) @(negedge SD_CLK_IN);
        chk(nm, sig(which), lvl);
    endtask

    // Command-level reference: what the host must see when this command finishes.
    task automatic predict(input int kind, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [15:0] setting, input logic [15:0] tout,
                           input logic [15:0] status, input logic [39:0] rsp,
                           input int c0, output exp_t e);
        e.cmd     = {2'b01, idx, arg};
        e.setting = setting & 16'h7FFF;
        if (kind == K_TOUT) begin
            e.err      = 3'b001;
            // Counter starts at 0 on the accepting edge and aborts when it equals the
            // limit, so CMD_DONE appears limit+1 edges after the accepting edge.
            e.done_cyc = c0 + int'(tout) + 2;
            n_tout_exp++;
        end else begin
            e.err[0]   = 1'b0;
            e.err[1]   = setting[7] && !status[5];
            e.err[2]   = setting[15] && (rsp[37:32] != idx);
            e.done_cyc = -1;
            if (status[3:0] == 4'h6) begin
                m_resp = rsp[31:0];
                m_ridx = rsp[37:32];
            end
        end
        e.resp = m_resp;
        e.ridx = m_ridx;
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_busy"},    BUSY,        0);
        chk({p, "_done"},    CMD_DONE,    0);
        chk({p, "_req"},     SER_REQ,     0);
        chk({p, "_ack"},     SER_ACK,     0);
        chk({p, "_goidle"},  SER_GO_IDLE, 0);
        chk({p, "_sercmd"},  SER_CMD,     0);
        chk({p, "_serset"},  SER_SETTING, 0);
        chk({p, "_resp"},    RESPONSE,    0);
        chk({p, "_rspidx"},  RSP_INDEX,   0);
        chk({p, "_err"},     ERR_FLAGS,   0);
    endtask

    task automatic send_event(input logic [3:0] ph);
        SER_STATUS     = {12'h000, ph};
        SER_RSP        = {$urandom, $urandom};
        SER_STATUS_REQ = 1'b1;
        wait_sig(1, 1'b1, 20, "ev_ack_rise");
        SER_STATUS_REQ = 1'b0;
        wait_sig(1, 1'b0, 20, "ev_ack_fall");
    endtask

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [15:0] setting, input logic [15:0] tout, output int c0);
        @(negedge SD_CLK_IN);
        CMD_INDEX   = idx;
        CMD_ARG     = arg;
        CMD_SETTING = setting;
        TIMEOUT_IN  = tout;
        NEW_CMD     = 1'b1;
        c0          = cyc;
    endtask

    task automatic run_cmd(input int kind, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [15:0] setting, input logic [15:0] tout,
                           input bit crc_ok, input logic [5:0] rsp_idx,
                           input logic [31:0] rsp_arg, input bit interfere);
        logic [15:0] st_fin;
        logic [39:0] rsp_fin;
        exp_t        e;
        int          c0;
        if (kind == K_RSP) begin
            st_fin  = crc_ok ? 16'h0066 : 16'h0046;
            rsp_fin = {2'b00, rsp_idx, rsp_arg};
        end else begin
            st_fin  = 16'h0044;
            rsp_fin = {2'b00, rsp_idx, rsp_arg};
        end
        issue(idx, arg, setting, tout, c0);
        predict(kind, idx, arg, setting, tout, st_fin, rsp_fin, c0, e);
        exp_q.push_back(e);
        @(negedge SD_CLK_IN);
        NEW_CMD = 1'b0;
        chk("req_latency", SER_REQ, 1);
        chk("busy_set", BUSY, 1);
        repeat (2) @(negedge SD_CLK_IN);
        SER_READY = 1'b0;

        if (interfere) begin
            // A second request while busy must leave every latched field alone.
            @(negedge SD_CLK_IN);
            CMD_INDEX   = 6'($urandom);
            CMD_ARG     = $urandom;
            CMD_SETTING = 16'($urandom);
            TIMEOUT_IN  = 16'd3;
            NEW_CMD     = 1'b1;
            @(negedge SD_CLK_IN);
            NEW_CMD     = 1'b0;
        end

        if (kind == K_TOUT) begin
            wait_sig(3, 1'b1, int'(tout) + 50, "goidle_seen");
            SER_READY = 1'b1;
            wait_sig(2, 1'b0, 10, "busy_clear_tout");
        end else begin
            if (kind == K_NORSP) begin
                send_event(4'h2);
            end else begin
                int nev = $urandom_range(1, 3);
                for (int i = 0; i < nev; i++) begin
                    case ($urandom % 4)
                        0:       send_event(4'h1);
                        1:       send_event(4'h2);
                        2:       send_event(4'h3);
                        default: send_event(4'h5);
                    endcase
                end
            end
            SER_STATUS = st_fin;
            SER_RSP    = rsp_fin;
            SER_STATUS_REQ = 1'b1;
            if (kind == K_NORSP) begin
                repeat (4) @(negedge SD_CLK_IN);
                SER_STATUS_REQ = 1'b0;
                SER_READY      = 1'b1;
            end else begin
                wait_sig(1, 1'b1, 20, "fin_ack_rise");
                SER_STATUS_REQ = 1'b0;
                repeat (4) @(negedge SD_CLK_IN);
                chk("ack_hold", SER_ACK, 1);
                SER_READY = 1'b1;
            end
            wait_sig(2, 1'b0, 30, "busy_clear");
            chk("ack_release", SER_ACK, 0);
        end
        repeat (6) @(negedge SD_CLK_IN);
    endtask

    task automatic run_reset_mid_cmd();
        int c0;
        issue(6'd55, 32'hCAFE_0001, 16'h00B0, 16'd0, c0);
        @(negedge SD_CLK_IN);
        NEW_CMD = 1'b0;
        repeat (2) @(negedge SD_CLK_IN);
        SER_READY = 1'b0;
        wait_sig(0, 1'b0, 20, "rst_reached_active");
        SER_STATUS     = 16'h0002;
        SER_STATUS_REQ = 1'b1;
        repeat (2) @(negedge SD_CLK_IN);
        CMD_INDEX = 6'd9;
        CMD_ARG   = 32'h1234_5678;
        NEW_CMD   = 1'b1;
        @(negedge SD_CLK_IN);
        NEW_CMD   = 1'b0;
        chk("ignored_cmd", SER_CMD, {2'b01, 6'd55, 32'hCAFE_0001});
        repeat (2) @(negedge SD_CLK_IN);
        RST_IN = 1'b1;
        #1;
        check_reset_outputs("midrst");
        SER_STATUS_REQ = 1'b0;
        SER_READY      = 1'b1;
        repeat (3) @(negedge SD_CLK_IN);
        RST_IN = 1'b0;
        m_resp = '0;
        m_ridx = '0;
        repeat (12) @(negedge SD_CLK_IN);
        chk("post_rst_busy", BUSY, 0);
    endtask

    // Scoreboard monitor: compares each completion against the oldest prediction.
    logic go_prev   = 1'b0;
    logic done_prev = 1'b0;
    always @(negedge SD_CLK_IN) begin
        if (!RST_IN) begin
            if (SER_GO_IDLE) begin
                go_cnt++;
                chk("goidle_pulse", go_prev, 0);
            end
            if (CMD_DONE) begin
                chk("done_pulse", done_prev, 0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: CMD_DONE at cycle %0d with no command outstanding", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_sercmd",  SER_CMD,     e.cmd);
                    chk("sb_serset",  SER_SETTING, e.setting);
                    chk("sb_resp",    RESPONSE,    e.resp);
                    chk("sb_rspidx",  RSP_INDEX,   e.ridx);
                    chk("sb_err",     ERR_FLAGS,   e.err);
                    chk("sb_busy",    BUSY,        0);
                    if (e.done_cyc >= 0) chk("sb_tout_cycle", cyc, e.done_cyc);
                end
            end
        end
        go_prev   = SER_GO_IDLE;
        done_prev = CMD_DONE;
    end

    initial begin
        RST_IN         = 1'b1;
        NEW_CMD        = 1'b0;
        CMD_INDEX      = '0;
        CMD_ARG        = '0;
        CMD_SETTING    = '0;
        TIMEOUT_IN     = '0;
        SER_READY      = 1'b1;
        SER_STATUS_REQ = 1'b0;
        SER_STATUS     = '0;
        SER_RSP        = '0;
        repeat (3) @(negedge SD_CLK_IN);
        check_reset_outputs("reset");
        RST_IN = 1'b0;
        repeat (4) @(negedge SD_CLK_IN);

        // Directed cases
        run_cmd(K_NORSP, 6'd0,  32'h0,      16'h0000, 16'd0,   1, 6'd0,  32'h0,      0);
        run_cmd(K_RSP,   6'd8,  32'h1AA,    16'h00B0, 16'd0,   1, 6'd8,  32'h1AA,    0);
        run_cmd(K_RSP,   6'd8,  32'h1AA,    16'h00B0, 16'd0,   0, 6'd8,  32'h1AA,    0);
        run_cmd(K_RSP,   6'd17, 32'h200,    16'h80B0, 16'd0,   1, 6'd18, 32'h900,    0);
        run_cmd(K_TOUT,  6'd2,  32'h0,      16'h0088, 16'd100, 1, 6'd0,  32'h0,      0);
        run_cmd(K_RSP,   6'd13, 32'h55AA,   16'h00B0, 16'd0,   1, 6'd13, 32'hBEEF,   1);
        run_reset_mid_cmd();

        // Randomized commands
        for (int n = 0; n < 24; n++) begin
            int          kind;
            logic [5:0]  idx;
            logic [15:0] tout;
            kind = $urandom % 3;
            idx  = 6'($urandom);
            tout = (kind == K_TOUT) ? 16'($urandom_range(20, 120))
                                    : (($urandom % 2) ? 16'd0 : 16'd400);
            run_cmd(kind, idx, $urandom, 16'($urandom), tout, 1'($urandom),
                    ($urandom % 2) ? idx : 6'($urandom), $urandom,
                    (kind != K_TOUT) && ($urandom % 2 == 1));
        end

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge SD_CLK_IN);
        chk("queue_drained", exp_q.size(), 0);
        chk("goidle_count", go_cnt, n_tout_exp);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
